// File: rtl/arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_BUSY_IF  = 2'd1;
    localparam logic [1:0] ARB_BUSY_DM  = 2'd2;
    localparam logic [1:0] ARB_DRAIN_IF = 2'd3;

    // Requester identifiers used by the grant logic
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/imem_dmem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch
// and the MEM stage. DM normally wins a collision; a saturating starvation
// counter hands the port to IF after STARVE_LIMIT consecutive DM grants.
module imem_dmem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_flush,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_done,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int         BE_W    = DATA_W / 8;
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] starve_cnt;
    logic       if_elig;
    logic       grant_valid;
    logic       grant_id;

    // Arbitration: only evaluated in IDLE, so no grant can happen on an ack cycle
    always_comb begin
        if_elig     = if_req & ~if_flush;
        grant_valid = 1'b0;
        grant_id    = REQ_IF;
        if (state == ARB_IDLE) begin
            if (dm_req && (!if_elig || (starve_cnt < LIMIT_C))) begin
                grant_valid = 1'b1;
                grant_id    = REQ_DM;
            end else if (if_elig) begin
                grant_valid = 1'b1;
                grant_id    = REQ_IF;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a flush during a fetch drains it rather than aborting the bus cycle
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_next = (grant_id == REQ_DM) ? ARB_BUSY_DM : ARB_BUSY_IF;
                end
            end
            ARB_BUSY_IF: begin
                if (mem_ack_i) begin
                    state_next = ARB_IDLE;
                end else if (if_flush) begin
                    state_next = ARB_DRAIN_IF;
                end
            end
            ARB_BUSY_DM,
            ARB_DRAIN_IF: begin
                if (mem_ack_i) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Output decode: request strobe, done pulses and stalls (stalls forced low in reset)
    always_comb begin
        mem_req_o = (state != ARB_IDLE);
        if_done   = (state == ARB_BUSY_IF) & mem_ack_i & ~if_flush;
        dm_done   = (state == ARB_BUSY_DM) & mem_ack_i;
        stall_if  = rst_n & if_req & ~if_done;
        stall_mem = rst_n & dm_req & ~dm_done;
    end

    assign if_rdata = mem_rdata_i;
    assign dm_rdata = mem_rdata_i;

    // Starvation counter: counts DM wins over a waiting IF, saturating at 15
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!if_req) begin
            starve_cnt <= 4'd0;
        end else if (grant_valid && (grant_id == REQ_IF)) begin
            starve_cnt <= 4'd0;
        end else if (grant_valid && (grant_id == REQ_DM) && if_elig && (starve_cnt != 4'hF)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Operand capture: the winner's operands are held until the access ends
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= '0;
        end else if (grant_valid) begin
            if (grant_id == REQ_DM) begin
                mem_we_o    <= dm_we;
                mem_addr_o  <= dm_addr;
                mem_wdata_o <= dm_wdata;
                mem_be_o    <= dm_be;
            end else begin
                mem_we_o    <= 1'b0;
                mem_addr_o  <= if_addr;
                mem_wdata_o <= '0;
                mem_be_o    <= {BE_W{1'b1}};
            end
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed self-checking bench for imem_dmem_port_arbiter.
module tb_imem_dmem_port_arbiter;
    import arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_done;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        stall_if, stall_mem;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;

    int errors = 0;
    int checks = 0;

    imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then driven mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b1; dm_req = 1'b1; if_flush = 1'b0; mem_ack_i = 1'b1;
        if_addr = 32'h0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
        mem_rdata_i = 32'h0;
        tick(); tick();
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
        checks++; if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stalls got=%b%b exp=00", stall_if, stall_mem); end
        checks++; if (if_done !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b%b exp=00", if_done, dm_done); end
        checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 69'd0) begin errors++; $display("FAIL reset_mem_regs addr=%h wdata=%h be=%h we=%b exp=0", mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o); end
        if_req = 1'b0; dm_req = 1'b0; mem_ack_i = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_if_only();
        // cycle 0: request in IDLE
        if_req = 1'b1; if_addr = 32'h100; #1;
        checks++; if (stall_if !== 1'b1 || mem_req_o !== 1'b0) begin errors++; $display("FAIL if_c0 stall_if=%b mem_req=%b exp=1,0", stall_if, mem_req_o); end
        tick();
        // cycle 1: memory acks immediately
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; #1;
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin errors++; $display("FAIL if_c1_bus req=%b addr=%h exp=1,100", mem_req_o, mem_addr_o); end
        checks++; if (mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin errors++; $display("FAIL if_c1_we_be we=%b be=%h exp=0,f", mem_we_o, mem_be_o); end
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'hCAFEF00D || stall_if !== 1'b0) begin errors++; $display("FAIL if_c1_done done=%b rdata=%h stall=%b exp=1,cafef00d,0", if_done, if_rdata, stall_if); end
        tick();
        if_req = 1'b0; mem_ack_i = 1'b0; #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL if_c2_idle mem_req=%b exp=0", mem_req_o); end
        tick();
    endtask

    task automatic test_dm_priority();
        if_req = 1'b1; if_addr = 32'h104;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        #1;
        checks++; if (stall_mem !== 1'b1 || stall_if !== 1'b1) begin errors++; $display("FAIL prio_stalls got=%b%b exp=11", stall_if, stall_mem); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            mem_ack_i = (c == 3); #1;
            checks++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h2000 ||
                mem_wdata_o !== 32'hDEADBEEF || mem_be_o !== 4'b0011) begin
                errors++; $display("FAIL prio_dm_bus_c%0d req=%b we=%b addr=%h wdata=%h be=%b exp=1,1,2000,deadbeef,0011",
                                   c, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
            end
            checks++; if (dm_done !== (c == 3) || if_done !== 1'b0) begin errors++; $display("FAIL prio_done_c%0d dm=%b if=%b exp=%b,0", c, dm_done, if_done, (c == 3)); end
        end
        tick();
        dm_req = 1'b0; mem_ack_i = 1'b0; #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL prio_no_b2b mem_req=%b exp=0", mem_req_o); end
        tick();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h13579BDF; #1;
        checks++; if (mem_addr_o !== 32'h104 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF || if_done !== 1'b1) begin errors++; $display("FAIL prio_if_after addr=%h we=%b be=%h done=%b exp=104,0,f,1", mem_addr_o, mem_we_o, mem_be_o, if_done); end
        tick();
        if_req = 1'b0; mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        if_req = 1'b1; if_addr = 32'h200;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
        for (int g = 0; g < 5; g++) begin
            #1;
            if (g == 4) begin
                checks++; if (dut.starve_cnt !== 4'd4) begin errors++; $display("FAIL starve_cnt_full got=%0d exp=4", dut.starve_cnt); end
            end
            tick();
            mem_ack_i = 1'b1; #1;
            if (g < 4) begin
                checks++; if (mem_addr_o !== 32'h3000 || dm_done !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL starve_dm_g%0d addr=%h dm=%b if=%b exp=3000,1,0", g, mem_addr_o, dm_done, if_done); end
            end else begin
                checks++; if (mem_addr_o !== 32'h200 || if_done !== 1'b1 || dm_done !== 1'b0) begin errors++; $display("FAIL starve_if_g%0d addr=%h if=%b dm=%b exp=200,1,0", g, mem_addr_o, if_done, dm_done); end
            end
            tick();
            mem_ack_i = 1'b0;
        end
        #1;
        checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL starve_cnt_clear got=%0d exp=0", dut.starve_cnt); end
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_flush_drain();
        if_req = 1'b1; if_addr = 32'h400;
        tick();                                     // busy cycle 1
        #1;
        checks++; if (mem_req_o !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL drain_b1 req=%b done=%b exp=1,0", mem_req_o, if_done); end
        tick();                                     // busy cycle 2: redirect
        if_flush = 1'b1; if_req = 1'b0; #1;
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL drain_b2 done=%b exp=0", if_done); end
        tick();                                     // busy cycle 3
        if_flush = 1'b0; #1;
        checks++; if (dut.state !== ARB_DRAIN_IF || mem_req_o !== 1'b1 || mem_addr_o !== 32'h400) begin errors++; $display("FAIL drain_state st=%0d req=%b addr=%h exp=3,1,400", dut.state, mem_req_o, mem_addr_o); end
        tick();                                     // busy cycle 4: ack
        mem_ack_i = 1'b1; #1;
        checks++; if (if_done !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL drain_ack done=%b req=%b exp=0,1", if_done, mem_req_o); end
        tick();
        mem_ack_i = 1'b0; if_req = 1'b1; if_addr = 32'h500; #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL drain_idle req=%b exp=0", mem_req_o); end
        tick();
        mem_ack_i = 1'b1; #1;
        checks++; if (if_done !== 1'b1 || mem_addr_o !== 32'h500) begin errors++; $display("FAIL drain_next done=%b addr=%h exp=1,500", if_done, mem_addr_o); end
        tick();
        if_req = 1'b0; mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_flush_edges();
        // flush in IDLE makes IF ineligible
        if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h600;
        tick(); #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL flush_idle req=%b exp=0", mem_req_o); end
        if_flush = 1'b0;
        tick();
        // flush coincident with ack: done suppressed, back to IDLE
        if_flush = 1'b1; mem_ack_i = 1'b1; #1;
        checks++; if (if_done !== 1'b0 || mem_req_o !== 1'b1) begin errors++; $display("FAIL flush_on_ack done=%b req=%b exp=0,1", if_done, mem_req_o); end
        tick();
        if_flush = 1'b0; if_req = 1'b0; mem_ack_i = 1'b0; #1;
        checks++; if (dut.state !== ARB_IDLE) begin errors++; $display("FAIL flush_on_ack_state got=%0d exp=0", dut.state); end
        // flush has no effect on a store
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h700; dm_wdata = 32'h11223344; dm_be = 4'hF;
        tick();
        if_flush = 1'b1; mem_ack_i = 1'b1; #1;
        checks++; if (dm_done !== 1'b1 || mem_we_o !== 1'b1) begin errors++; $display("FAIL flush_store done=%b we=%b exp=1,1", dm_done, mem_we_o); end
        tick();
        if_flush = 1'b0; dm_req = 1'b0; mem_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h800; dm_wdata = 32'hA5A5A5A5; dm_be = 4'hF;
        tick();
        #1;
        checks++; if (mem_req_o !== 1'b1 || stall_mem !== 1'b1) begin errors++; $display("FAIL arst_busy req=%b stall=%b exp=1,1", mem_req_o, stall_mem); end
        #1 rst_n = 1'b0; mem_ack_i = 1'b1;
        #1;
        checks++; if (mem_req_o !== 1'b0 || dm_done !== 1'b0 || stall_mem !== 1'b0) begin errors++; $display("FAIL arst_now req=%b done=%b stall=%b exp=0,0,0", mem_req_o, dm_done, stall_mem); end
        checks++; if (mem_addr_o !== 32'h0 || mem_we_o !== 1'b0) begin errors++; $display("FAIL arst_regs addr=%h we=%b exp=0,0", mem_addr_o, mem_we_o); end
        dm_req = 1'b0; mem_ack_i = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        mem_ack_i = 1'b1; #1;
        checks++; if (dm_done !== 1'b0 || if_done !== 1'b0 || dut.state !== ARB_IDLE) begin errors++; $display("FAIL arst_stray dm=%b if=%b st=%0d exp=0,0,0", dm_done, if_done, dut.state); end
        tick();
        mem_ack_i = 1'b0; #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL arst_after req=%b exp=0", mem_req_o); end
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_dm_priority();
        test_starvation();
        test_flush_drain();
        test_flush_edges();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
